// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter and run-control stage feeding instruction memory.
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-high reset
//   Start               run request; high arms, falling edge launches
//   Halt                decoded halt at the current PC (RUN only)
//   BranchAbs           unconditional absolute jump to Target (RUN only)
//   BranchRel, Zero     relative branch by signed Target, taken when Zero (RUN only)
//   Target              absolute target (zero-extended) or signed relative offset
//   PC                  current instruction address
//   Running             high while in RUN
//   Ack                 registered done flag, high in DONE
//   Cycles              saturating count of RUN edges in the current/last program
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchAbs,
  input  logic             BranchRel,
  input  logic             Zero,
  input  logic [OFF_W-1:0] Target,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Ack,
  output logic [CNT_W-1:0] Cycles
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  localparam int W = PC_W > OFF_W ? PC_W : OFF_W;
  state_t state, next;
  logic [W-1:0] tgt_z;
  logic signed [W-1:0] tgt_s;
  logic [PC_W-1:0] pc_next;
  // Widen first so both zero/sign extension and truncation work for any PC_W/OFF_W
  assign tgt_z = W'(Target);
  assign tgt_s = W'(signed'(Target));
  assign pc_next = BranchAbs ? tgt_z[PC_W-1:0] :
                   (BranchRel && Zero) ? PC + tgt_s[PC_W-1:0] : PC + PC_W'(1);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  always_comb
    case (state)
      IDLE:    next = Start ? ARMED : IDLE;
      ARMED:   next = Start ? ARMED : RUN;
      RUN:     next = Start ? ARMED : Halt ? DONE : RUN;
      default: next = Start ? ARMED : DONE;
    endcase
  always_comb Running = state == RUN;
  // Entering or sitting in ARMED zeroes PC and Cycles, so RUN always starts clean at 0
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      PC     <= '0;
      Cycles <= '0;
      Ack    <= 1'b0;
    end else begin
      Ack <= next == DONE;
      if (next == ARMED || state == ARMED) begin
        PC     <= '0;
        Cycles <= '0;
      end else if (state == RUN) begin
        Cycles <= &Cycles ? Cycles : Cycles + CNT_W'(1);
        if (!Halt) PC <= pc_next;
      end
    end
endmodule
